// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pulls an N-word burst from a FIFO read port and replays
// it on a valid/ready stream. A FIFO read returns data one cycle after rd_en,
// and rd_val=0 means the FIFO was empty, so that word is requested again.
// Ports: clk, reset (async, active high); cmd_valid/cmd_len/cmd_ready burst
// command; busy; fifo_rd_en/fifo_rd_data/fifo_rd_val FIFO read side;
// m_data/m_valid/m_ready/m_last output stream; done one-cycle completion pulse.
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8,
    parameter int BUF_DEPTH  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  cmd_ready,
    output logic                  busy,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_val,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  done
);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(BUF_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(BUF_DEPTH - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]            state;
    logic [LEN_WIDTH-1:0]  rcv_left;
    logic [LEN_WIDTH-1:0]  out_left;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         buf_count;
    logic [CW:0]           committed;
    logic                  push;
    logic                  pop;
    logic                  accept;
    logic                  finish;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Slots already spoken for: buffered words plus the one read in flight.
    // Requests only go out when the reply is guaranteed a slot, so the
    // request never depends on m_ready.
    assign committed  = (CW + 1)'(buf_count) + (CW + 1)'(inflight);
    assign fifo_rd_en = (state == RUN)
                      && (rcv_left > LEN_WIDTH'(inflight))
                      && (committed < DEPTH_C);

    assign cmd_ready = (state == IDLE);
    assign busy      = (state == RUN);
    assign m_valid   = (buf_count != '0);
    assign m_data    = m_valid ? mem[rd_ptr] : '0;
    assign m_last    = m_valid && (out_left == LEN_WIDTH'(1));

    // FIFO reply lines hold stale values unless a read was issued last cycle.
    assign push   = inflight && fifo_rd_val;
    assign pop    = m_valid && m_ready;
    assign accept = (state == IDLE) && cmd_valid;
    assign finish = pop && (out_left == LEN_WIDTH'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rcv_left  <= '0;
            out_left  <= '0;
            inflight  <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            buf_count <= '0;
            done      <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            done     <= finish || (accept && (cmd_len == '0));

            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (push && !pop) begin
                buf_count <= buf_count + 1'b1;
            end else if (pop && !push) begin
                buf_count <= buf_count - 1'b1;
            end

            case (state)
                IDLE: begin
                    if (accept && (cmd_len != '0)) begin
                        rcv_left <= cmd_len;
                        out_left <= cmd_len;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (push) begin
                        rcv_left <= rcv_left - 1'b1;
                    end
                    if (pop) begin
                        out_left <= out_left - 1'b1;
                    end
                    if (finish) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= fifo_rd_data;
        end
    end
endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Consumer for the read side of the team's FIFOs: rd_en request, rd_data/rd_val returned one cycle later, rd_val=0 meaning the FIFO was empty.
- Accepts a burst command of N words and pulls exactly N valid words from the FIFO, retrying on empty.
- Presents the words on a valid/ready output stream with m_last on the final word, then pulses done.
- Sits between a shear/ring FIFO and a downstream packetiser or DMA.

Parameters:
- DATA_WIDTH, 8, width of FIFO and stream data.
- LEN_WIDTH, 8, width of the burst length field; max burst 2**LEN_WIDTH-1.
- BUF_DEPTH, 3, output skid buffer entries; min 3 for full throughput.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  burst command valid.
- cmd_len  in  LEN_WIDTH  number of words to read.
- cmd_ready  out  1  high in IDLE only.
- busy  out  1  high in RUN.
- fifo_rd_en  out  1  read request to FIFO.
- fifo_rd_data  in  DATA_WIDTH  FIFO data, valid the cycle after fifo_rd_en.
- fifo_rd_val  in  1  FIFO data-valid, qualifies fifo_rd_data the cycle after fifo_rd_en.
- m_data  out  DATA_WIDTH  stream data (buffer head).
- m_valid  out  1  stream valid.
- m_ready  in  1  downstream accept.
- m_last  out  1  head word is the last of the burst.
- done  out  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (async, immediate): state IDLE; rcv_left=0, out_left=0, inflight=0; buffer empty; done=0.
  - Outputs while reset is held: fifo_rd_en=0, m_valid=0, m_last=0, m_data=0, cmd_ready=1, busy=0.
- Reset mid-burst: in-flight and buffered words are discarded (lost from the FIFO; accepted).
- IDLE state:
  - cmd handshake is cmd_valid & cmd_ready.
  - cmd_len!=0: latch rcv_left=out_left=cmd_len, go to RUN.
  - cmd_len==0: stay in IDLE, done=1 next cycle.
- RUN state:
  - cmd_ready=0; cmd_valid is ignored.
  - fifo_rd_en = (rcv_left > inflight) & (buf_count + inflight < BUF_DEPTH). This is registered-state only, with no combinational path from m_ready.
  - inflight <= fifo_rd_en, registered; a 1-bit value.
- Response handling:
  - fifo_rd_val and fifo_rd_data are sampled only in cycles where inflight=1; at all other times they are ignored, because the FIFO holds stale values.
  - inflight=1 & fifo_rd_val=1: push fifo_rd_data into the buffer, rcv_left--.
  - inflight=1 & fifo_rd_val=0: FIFO was empty; nothing is pushed and the word is re-requested on the next eligible cycle.
- Output stream:
  - m_valid = buf_count!=0; m_data = head; m_last = m_valid & (out_left==1).
  - Pop on m_valid & m_ready; out_left--.
  - m_data and m_last are stable while m_valid & !m_ready.
  - A push and a pop in the same cycle leave buf_count unchanged; ordering is strictly FIFO.
- Completion:
  - Pop with out_left==1 moves the block to IDLE; done=1 in the following cycle, for one cycle.
  - A new command may be accepted in that same done cycle.
- Latency, FIFO non-empty, m_ready=1:
  - cmd accepted at edge E0.
  - fifo_rd_en high in cycle E0..E1.
  - Data pushed at E2; m_valid high from E2.
  - Steady state is one word per cycle with BUF_DEPTH>=3.
- Widths: counters are LEN_WIDTH bits. No wrap can occur, because rcv_left >= inflight is maintained and neither counter decrements past 0.
- Invariants:
  - buf_count + inflight <= BUF_DEPTH.
  - Number of fifo_rd_val=1 pushes == cmd_len per burst.

Test Plan:
- FIFO preloaded 0x11..0x15, cmd_len=5, m_ready=1 → m_data 11,12,13,14,15 on consecutive cycles; m_last only with 0x15; exactly 5 fifo_rd_en cycles; done one cycle after the 0x15 handshake.
- Empty FIFO, cmd_len=3; FIFO writes 0xA0 at cycle 10 and 0xA1,0xA2 at cycle 20 → fifo_rd_en retries with no pushes while rd_val=0; output A0,A1,A2 only; done after A2.
- cmd_len=8, data 0..7, m_ready pattern 1,0,0,1,0,1,1,0 repeating → output order 0..7 with no loss or duplication; m_data held during stalls; buf_count never exceeds 3; fifo_rd_en low whenever buf_count+inflight=3.
- cmd_len=0 → done pulse the cycle after accept; no fifo_rd_en; cmd_ready stays 1.
- cmd_len=6; assert reset asynchronously (off-edge) after 2 words → m_valid, fifo_rd_en, busy drop immediately. After release: cmd_ready=1; cmd_len=2 on data 0x40,0x41 → 0x40,0x41 with m_last on 0x41.
- cmd_len=255 with FIFO continuously refilled → 255 words, m_last on the 255th; cmd_valid pulsed with cmd_len=4 mid-burst is ignored (no extra words).
